// File: rtl/thresholding_loader.sv
// Streaming threshold loader: turns an ascending per-channel stream into
// core write strobes {channel, index} and flags out-of-order thresholds.
module thresholding_loader #(
  parameter int N = 2,
  parameter int M = 8,
  parameter int C = 2,
  parameter bit SIGNED = 1'b0,
  localparam int A_BITS = $clog2(C) + N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [M-1:0]      s_tdata,
  output logic              twe,
  output logic [A_BITS-1:0] twa,
  output logic [M-1:0]      twd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [A_BITS-1:0] err_addr
);

  localparam int CB = (C > 1) ? $clog2(C) : 1;
  localparam logic [N-1:0]  IMAX = N'((1 << N) - 2);
  localparam logic [CB-1:0] CMAX = CB'(C - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t state, nxt;

  logic [N-1:0]      idx;
  logic [CB-1:0]     cnl;
  logic [M-1:0]      prev;
  logic [A_BITS-1:0] addr;
  logic              hs;
  logic              last;
  logic              le;
  logic              viol;

  // a start coinciding with a beat wins; the beat is dropped
  assign s_tready = (state == LOAD);
  assign busy     = (state == LOAD);
  assign done     = (state == DONE);
  assign hs       = s_tvalid & s_tready & ~start;
  assign last     = (cnl == CMAX) && (idx == IMAX);

  assign le = SIGNED ? ($signed(s_tdata) <= $signed(prev))
                     : (s_tdata <= prev);
  assign viol = hs && (idx != '0) && le;

  generate
    if (C > 1) begin : g_multi
      assign addr = {cnl, idx};
    end else begin : g_single
      assign addr = idx;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = LOAD;
      LOAD:    if (start) nxt = LOAD;
               else if (hs && last) nxt = DONE;
      DONE:    if (start) nxt = LOAD;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      twe      <= 1'b0;
      twa      <= '0;
      twd      <= '0;
      err      <= 1'b0;
      err_addr <= '0;
      idx      <= '0;
      cnl      <= '0;
      prev     <= '0;
    end else begin
      twe <= hs;
      if (hs) begin
        twa  <= addr;
        twd  <= s_tdata;
        prev <= s_tdata;
        if (idx == IMAX) begin
          idx <= '0;
          cnl <= (cnl == CMAX) ? '0 : cnl + 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
        if (viol && !err) begin
          err      <= 1'b1;
          err_addr <= addr;
        end
      end
      if (start) begin
        idx      <= '0;
        cnl      <= '0;
        err      <= 1'b0;
        err_addr <= '0;
      end
    end
  end

endmodule
